// File: rtl/ritc_storage_readout.sv
// Capture-and-readout initiator for the RITC sample-storage bus: clear, trig, wait for done,
// then stream every sample's 32-bit slices on valid/ready. Optional header word: RDOUT_HEADER_EN.
module ritc_storage_readout #(
   parameter int unsigned DEPTH          = 512,
   parameter int unsigned NUM_SLICES     = 3,
   parameter int unsigned RD_LAT         = 2,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic        user_clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   output logic        busy_o,
   output logic        timeout_o,
   output logic        trig_o,
   output logic        clear_o,
   input  logic        done_i,
   input  logic        sync_latch_i,
   output logic [10:0] stor_addr_o,
   output logic        stor_sel_o,
   output logic        stor_wr_o,
   output logic        stor_rd_o,
   input  logic [31:0] stor_dat_i,
   output logic [31:0] m_dat_o,
   output logic        m_valid_o,
   input  logic        m_ready_i,
   output logic        m_last_o
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned LatW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [3:0] {
      StIdle,
      StClr,
      StTrg,
      StWaitLo,
      StWaitHi,
`ifdef RDOUT_HEADER_EN
      StHdr,
`endif
      StSeek,
      StLat,
      StSlice,
      StEmit,
      StDone
   } state_e;

   state_e            state_q;
   logic [9:0]        sample_q;
   logic [1:0]        slice_q;
   logic [CntW-1:0]   wait_cnt_q;
   logic [LatW-1:0]   lat_cnt_q;

   assign stor_rd_o = 1'b0;

`ifndef RDOUT_HEADER_EN
   logic unused_sync;
   assign unused_sync = sync_latch_i;
`endif

   always_ff @(posedge user_clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         sample_q    <= '0;
         slice_q     <= '0;
         wait_cnt_q  <= '0;
         lat_cnt_q   <= '0;
         busy_o      <= 1'b0;
         timeout_o   <= 1'b0;
         trig_o      <= 1'b0;
         clear_o     <= 1'b0;
         stor_addr_o <= '0;
         stor_sel_o  <= 1'b0;
         stor_wr_o   <= 1'b0;
         m_dat_o     <= '0;
         m_valid_o   <= 1'b0;
         m_last_o    <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start_i) begin
                  busy_o    <= 1'b1;
                  timeout_o <= 1'b0;
                  sample_q  <= '0;
                  slice_q   <= '0;
                  clear_o   <= 1'b1;
                  state_q   <= StClr;
               end
            end
            StClr: begin
               clear_o <= 1'b0;
               trig_o  <= 1'b1;
               state_q <= StTrg;
            end
            StTrg: begin
               trig_o     <= 1'b0;
               wait_cnt_q <= '0;
               state_q    <= StWaitLo;
            end
            // done_i may still show the previous capture until the storage flag resyncs
            StWaitLo: begin
               if (!done_i) begin
                  wait_cnt_q <= '0;
                  state_q    <= StWaitHi;
               end else if (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                  timeout_o <= 1'b1;
                  busy_o    <= 1'b0;
                  state_q   <= StIdle;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            StWaitHi: begin
               if (done_i) begin
`ifdef RDOUT_HEADER_EN
                  m_dat_o   <= {16'hB1C5, 7'd0, sync_latch_i, 8'(NUM_SLICES - 1)};
                  m_valid_o <= 1'b1;
                  m_last_o  <= 1'b0;
                  state_q   <= StHdr;
`else
                  stor_sel_o  <= 1'b1;
                  stor_wr_o   <= 1'b1;
                  stor_addr_o <= {2'd0, sample_q[8:0]};
                  state_q     <= StSeek;
`endif
               end else if (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                  timeout_o <= 1'b1;
                  busy_o    <= 1'b0;
                  state_q   <= StIdle;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
`ifdef RDOUT_HEADER_EN
            StHdr: begin
               if (m_ready_i) begin
                  m_valid_o   <= 1'b0;
                  stor_sel_o  <= 1'b1;
                  stor_wr_o   <= 1'b1;
                  stor_addr_o <= {2'd0, sample_q[8:0]};
                  state_q     <= StSeek;
               end
            end
`endif
            StSeek: begin
               stor_sel_o <= 1'b0;
               stor_wr_o  <= 1'b0;
               lat_cnt_q  <= '0;
               state_q    <= StLat;
            end
            StLat: begin
               if (lat_cnt_q == LatW'(RD_LAT - 1)) begin
                  stor_addr_o[10:9] <= slice_q;
                  state_q           <= StSlice;
               end else begin
                  lat_cnt_q <= lat_cnt_q + 1'b1;
               end
            end
            // stor_dat_i is a combinational mux of addr[10:9], so it is valid this cycle
            StSlice: begin
               m_dat_o   <= stor_dat_i;
               m_valid_o <= 1'b1;
               m_last_o  <= (sample_q == 10'(DEPTH - 1)) && (slice_q == 2'(NUM_SLICES - 1));
               state_q   <= StEmit;
            end
            StEmit: begin
               if (m_ready_i) begin
                  m_valid_o <= 1'b0;
                  m_last_o  <= 1'b0;
                  if (slice_q != 2'(NUM_SLICES - 1)) begin
                     slice_q           <= slice_q + 2'd1;
                     stor_addr_o[10:9] <= slice_q + 2'd1;
                     state_q           <= StSlice;
                  end else if (sample_q != 10'(DEPTH - 1)) begin
                     slice_q     <= '0;
                     sample_q    <= sample_q + 10'd1;
                     stor_sel_o  <= 1'b1;
                     stor_wr_o   <= 1'b1;
                     stor_addr_o <= {2'd0, sample_q[8:0] + 9'd1};
                     state_q     <= StSeek;
                  end else begin
                     busy_o  <= 1'b0;
                     state_q <= StDone;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
